// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the EEPROM data-path blocks: address width,
// general-call address and the slave address-phase state encoding.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W    = 7;
  localparam logic [6:0]  GEN_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK,
    ST_HOLD,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus edge, START and STOP event detection.
// Events are combinational from the last sync stage and its delayed copy.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic s_scl,
  output logic s_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  // Reset to the idle-bus level so releasing reset cannot fake an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= s_scl;
      r_sda_prev <= s_sda;
    end
  end

  assign s_scl     = r_scl_sync[SYNC_STAGES-1];
  assign s_sda     = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  s_scl & ~r_scl_prev;
  assign scl_fall  = ~s_scl &  r_scl_prev;
  assign start_det = ~s_sda &  r_sda_prev & s_scl & r_scl_prev;
  assign stop_det  =  s_sda & ~r_sda_prev & s_scl & r_scl_prev;

endmodule

// File: rtl/i2c_addr_matcher.sv
// I2C slave address front end: shifts in the address byte after START,
// compares against {DEV_PREFIX, pin_addr} (optionally general call) and ACKs.
module i2c_addr_matcher
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_PREFIX  = 7'b0001000,
  parameter int unsigned PIN_W       = 3,
  parameter bit          GEN_CALL_EN = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              scl_in,
  input  logic                              sda_in,
  input  logic [((PIN_W > 0) ? PIN_W : 1)-1:0] pin_addr,
  input  logic                              enable,
  output logic                              sda_oe,
  output logic                              addr_match,
  output logic                              rw,
  output logic                              gen_call,
  output logic                              selected,
  output logic [I2C_ADDR_W-1:0]             rx_addr
);

  logic w_s_scl, w_s_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .s_scl    (w_s_scl),
    .s_sda    (w_s_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start_det(w_start),
    .stop_det (w_stop)
  );

  logic [I2C_ADDR_W-1:0] w_dev_id;

  // DEV_PREFIX carries 7-PIN_W meaningful low bits.
  generate
    if (PIN_W == 0) begin : g_id_prefix
      assign w_dev_id = DEV_PREFIX;
    end else if (PIN_W >= 7) begin : g_id_pins
      assign w_dev_id = pin_addr[6:0];
    end else begin : g_id_mixed
      assign w_dev_id = {DEV_PREFIX[6-PIN_W:0], pin_addr};
    end
  endgenerate

  i2c_state_e            r_state;
  logic [6:0]            r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_sda_oe;
  logic                  r_addr_match;
  logic                  r_rw;
  logic                  r_gen_call;
  logic                  r_selected;
  logic [I2C_ADDR_W-1:0] r_rx_addr;

  logic [7:0] w_byte;
  logic       w_is_gc;
  logic       w_hit;

  assign w_byte  = {r_shift, w_s_sda};
  assign w_is_gc = GEN_CALL_EN && (w_byte[7:1] == GEN_CALL_ADDR) && !w_byte[0];
  assign w_hit   = (w_byte[7:1] == w_dev_id) || w_is_gc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sda_oe     <= 1'b0;
      r_addr_match <= 1'b0;
      r_rw         <= 1'b0;
      r_gen_call   <= 1'b0;
      r_selected   <= 1'b0;
      r_rx_addr    <= '0;
    end else begin
      r_addr_match <= 1'b0;
      if (!enable) begin
        r_state    <= ST_IDLE;
        r_sda_oe   <= 1'b0;
        r_selected <= 1'b0;
        r_rw       <= 1'b0;
        r_gen_call <= 1'b0;
        r_bit_cnt  <= '0;
      end else if (w_stop) begin
        r_state    <= ST_IDLE;
        r_sda_oe   <= 1'b0;
        r_selected <= 1'b0;
        r_rw       <= 1'b0;
        r_gen_call <= 1'b0;
      end else if (w_start) begin
        r_state    <= ST_SHIFT;
        r_sda_oe   <= 1'b0;
        r_selected <= 1'b0;
        r_bit_cnt  <= '0;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_rx_addr <= w_byte[7:1];
                if (w_hit) begin
                  r_addr_match <= 1'b1;
                  r_rw         <= w_byte[0];
                  r_gen_call   <= w_is_gc;
                  r_selected   <= 1'b1;
                  r_state      <= ST_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end
          // First fall (end of 8th bit) drives ACK, second fall releases it.
          ST_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_HOLD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe & enable;
  assign addr_match = r_addr_match;
  assign rw         = r_rw;
  assign gen_call   = r_gen_call;
  assign selected   = r_selected;
  assign rx_addr    = r_rx_addr;

endmodule

// File: tb/tb_i2c_addr_matcher.sv
// Directed bench: two matchers (general call off/on) share one bit-banged bus.
module tb_i2c_addr_matcher;
  import i2c_pkg::*;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] pin = 3'b101;

  logic       a_oe, a_match, a_rw, a_gc, a_sel;
  logic [6:0] a_rx;
  logic       g_oe, g_match, g_rw, g_gc, g_sel;
  logic [6:0] g_rx;

  int vectors = 0;
  int miscompares = 0;
  int a_match_cnt = 0;
  int g_match_cnt = 0;
  int a_oe_cnt = 0;
  int a_base, g_base, oe_base;

  i2c_addr_matcher #(
    .DEV_PREFIX(7'b0001000), .PIN_W(3), .GEN_CALL_EN(1'b0), .SYNC_STAGES(2)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda), .pin_addr(pin),
    .enable(enable), .sda_oe(a_oe), .addr_match(a_match), .rw(a_rw),
    .gen_call(a_gc), .selected(a_sel), .rx_addr(a_rx)
  );

  i2c_addr_matcher #(
    .DEV_PREFIX(7'b0001000), .PIN_W(3), .GEN_CALL_EN(1'b1), .SYNC_STAGES(2)
  ) u_g (
    .clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda), .pin_addr(pin),
    .enable(enable), .sda_oe(g_oe), .addr_match(g_match), .rw(g_rw),
    .gen_call(g_gc), .selected(g_sel), .rx_addr(g_rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_match) a_match_cnt++;
    if (g_match) g_match_cnt++;
    if (a_oe)    a_oe_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda = b;    #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic ack_bit(input string tag, input logic exp_a, input logic exp_g);
    sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    check({tag, "_a_oe_9th"}, {7'd0, a_oe}, {7'd0, exp_a});
    check({tag, "_g_oe_9th"}, {7'd0, g_oe}, {7'd0, exp_g});
    #Q;
    scl = 1'b0; #Q;
    check({tag, "_a_oe_rel"}, {7'd0, a_oe}, 8'd0);
    check({tag, "_g_oe_rel"}, {7'd0, g_oe}, 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_oe",    {7'd0, a_oe},    8'd0);
    check("rst_match", {7'd0, a_match}, 8'd0);
    check("rst_rw",    {7'd0, a_rw},    8'd0);
    check("rst_gc",    {7'd0, g_gc},    8'd0);
    check("rst_sel",   {7'd0, a_sel},   8'd0);
    check("rst_rx",    {1'b0, a_rx},    8'd0);
    reset_n = 1'b1; #Q;

    // 0x8B: address 0x45 read
    a_base = a_match_cnt;
    i2c_start(); send_byte(8'h8B); ack_bit("t1", 1'b1, 1'b1);
    check("t1_match_cnt", 8'(a_match_cnt - a_base), 8'd1);
    check("t1_rw",  {7'd0, a_rw},  8'd1);
    check("t1_sel", {7'd0, a_sel}, 8'd1);
    check("t1_rx",  {1'b0, a_rx},  8'h45);
    i2c_stop();
    check("t1_sel_stop", {7'd0, a_sel}, 8'd0);
    check("t1_rw_stop",  {7'd0, a_rw},  8'd0);

    // 0x90: address 0x48, mismatch
    a_base = a_match_cnt; oe_base = a_oe_cnt;
    i2c_start(); send_byte(8'h90); ack_bit("t2", 1'b0, 1'b0);
    check("t2_match_cnt", 8'(a_match_cnt - a_base), 8'd0);
    check("t2_oe_cnt",    8'(a_oe_cnt - oe_base),   8'd0);
    check("t2_rx",    {1'b0, a_rx}, 8'h48);
    check("t2_state", 8'(u_a.r_state), 8'(ST_IGNORE));
    i2c_stop();
    check("t2_state_stop", 8'(u_a.r_state), 8'(ST_IDLE));

    // General call write, then general-call address with rw=1
    a_base = a_match_cnt; g_base = g_match_cnt;
    i2c_start(); send_byte(8'h00); ack_bit("t3", 1'b0, 1'b1);
    check("t3_g_match_cnt", 8'(g_match_cnt - g_base), 8'd1);
    check("t3_a_match_cnt", 8'(a_match_cnt - a_base), 8'd0);
    check("t3_g_gc",  {7'd0, g_gc},  8'd1);
    check("t3_g_sel", {7'd0, g_sel}, 8'd1);
    check("t3_a_gc",  {7'd0, a_gc},  8'd0);
    i2c_stop();
    check("t3_g_gc_stop", {7'd0, g_gc}, 8'd0);
    g_base = g_match_cnt;
    i2c_start(); send_byte(8'h01); ack_bit("t3b", 1'b0, 1'b0);
    check("t3b_g_match_cnt", 8'(g_match_cnt - g_base), 8'd0);
    check("t3b_g_sel", {7'd0, g_sel}, 8'd0);
    i2c_stop();

    // 0x8A, repeated START, 0x8B
    a_base = a_match_cnt;
    i2c_start(); send_byte(8'h8A); ack_bit("t4a", 1'b1, 1'b1);
    check("t4_rw_first", {7'd0, a_rw},  8'd0);
    check("t4_sel_first", {7'd0, a_sel}, 8'd1);
    sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda = 1'b0; #Q;
    check("t4_sel_rstart", {7'd0, a_sel}, 8'd0);
    scl = 1'b0; #Q;
    send_byte(8'h8B); ack_bit("t4b", 1'b1, 1'b1);
    check("t4_rw_second", {7'd0, a_rw}, 8'd1);
    check("t4_match_cnt", 8'(a_match_cnt - a_base), 8'd2);
    check("t4_sel_second", {7'd0, a_sel}, 8'd1);
    i2c_stop();

    // STOP after four address bits, then a normal transfer
    oe_base = a_oe_cnt; a_base = a_match_cnt;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    i2c_stop();
    check("t5_state", 8'(u_a.r_state), 8'(ST_IDLE));
    check("t5_oe_cnt", 8'(a_oe_cnt - oe_base), 8'd0);
    check("t5_match_cnt", 8'(a_match_cnt - a_base), 8'd0);
    i2c_start(); send_byte(8'h8A); ack_bit("t5b", 1'b1, 1'b1);
    check("t5b_match_cnt", 8'(a_match_cnt - a_base), 8'd1);
    i2c_stop();

    // Asynchronous reset while ACK is driven
    i2c_start(); send_byte(8'h8A);
    sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    check("t6_oe_before_rst", {7'd0, a_oe}, 8'd1);
    #3 reset_n = 1'b0;
    #1;
    check("t6_oe_async", {7'd0, a_oe}, 8'd0);
    check("t6_sel_async", {7'd0, a_sel}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1; #Q;

    // Disabled: no ACK for a matching address
    a_base = a_match_cnt; g_base = g_match_cnt;
    enable = 1'b0;
    i2c_start(); send_byte(8'h8A); ack_bit("t7", 1'b0, 1'b0);
    check("t7_a_match_cnt", 8'(a_match_cnt - a_base), 8'd0);
    check("t7_g_match_cnt", 8'(g_match_cnt - g_base), 8'd0);
    check("t7_sel", {7'd0, a_sel}, 8'd0);
    i2c_stop();
    enable = 1'b1; #Q;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
